// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall, flush and bubble controls for the 5-stage core.
// Optional feature: define HAZARD_STALL_CNT_EN to add the stall_cnt performance counter.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       mem_access,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Write,
  output logic       IDEX_Flush,
  output logic       EXMEM_Write,
  output logic       MEMWB_Bubble,
  output logic [1:0] state,
  output logic       mem_error
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_set;
  logic               load_use;
  logic               mem_hold;
  logic               wd_expire;
  logic               cnt_below;

  assign state     = state_q;
  assign cnt_below = (cnt_q < CNT_W'(MEM_TIMEOUT));
  assign load_use  = ex_MemRead && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // State, watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (err_set) mem_error <= 1'b1;
    end
  end

  // Next state and pipeline controls; memory wait outranks branch, branch outranks load-use.
  always_comb begin
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b1;
    IDEX_Flush   = 1'b0;
    EXMEM_Write  = 1'b1;
    MEMWB_Bubble = 1'b0;
    state_d      = RUN;
    cnt_d        = '0;
    err_set      = 1'b0;
    mem_hold     = 1'b0;
    wd_expire    = 1'b0;

    // Frozen stages during MEM_WAIT: only ready or the watchdog end the wait.
    if (state_q == MEM_WAIT) begin
      mem_hold  = !mem_ready && cnt_below;
      wd_expire = !mem_ready && !cnt_below;
    end else begin
      mem_hold  = mem_access && !mem_ready;
    end

    if (mem_hold) begin
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      EXMEM_Write  = 1'b0;
      MEMWB_Bubble = 1'b1;
      state_d      = MEM_WAIT;
      cnt_d        = (state_q == MEM_WAIT) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    end else if (ex_branch_taken) begin
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
      state_d      = RUN;
    end else if (load_use) begin
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Flush   = 1'b1;
      state_d      = LOAD_STALL;
    end

    // A timed-out access must not write back.
    if (wd_expire) begin
      MEMWB_Bubble = 1'b1;
      err_set      = 1'b1;
    end

    if (!reset) begin
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IFID_Flush   = 1'b0;
      IDEX_Write   = 1'b0;
      IDEX_Flush   = 1'b0;
      EXMEM_Write  = 1'b0;
      MEMWB_Bubble = 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!PCWrite && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random traffic against a reference model.
module tb_hazard_ctrl;

  localparam int unsigned T = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_MemRead, ex_branch_taken, mem_access, mem_ready;
  logic       PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, MEMWB_Bubble;
  logic [1:0] state;
  logic       mem_error;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pipeline mode, cycles spent waiting, sticky error, stall count.
  int m_state = 0;
  int m_wait  = 0;
  bit m_err   = 1'b0;
  int m_stall = 0;

  hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Write(IDEX_Write), .IDEX_Flush(IDEX_Flush), .EXMEM_Write(EXMEM_Write),
    .MEMWB_Bubble(MEMWB_Bubble), .state(state), .mem_error(mem_error)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_MemRead = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
    mem_access = 1'b0; mem_ready = 1'b0;
  endtask

  // Called just after a negedge with inputs already applied; checks, then advances one clock.
  task automatic cycle(input string tag);
    logic [6:0] e;
    bit blocked, expire, lu;
    #1;
    lu = ex_MemRead && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    blocked = 1'b0;
    expire  = 1'b0;
    if (!reset) begin
      m_state = 0; m_wait = 0; m_err = 1'b0; m_stall = 0;
      e = 7'b0000001;
    end else begin
      if (m_state == 2) begin
        blocked = !mem_ready && m_wait < T;
        expire  = !mem_ready && m_wait >= T;
      end else begin
        blocked = mem_access && !mem_ready;
      end
      // {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, MEMWB_Bubble}
      if (blocked)              e = 7'b0000001;
      else if (ex_branch_taken) e = 7'b1111110;
      else if (lu)              e = 7'b0001110;
      else                      e = 7'b1101010;
      if (expire) e[0] = 1'b1;
    end
    chk({tag, ".ctrl"}, 16'({PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
                             EXMEM_Write, MEMWB_Bubble}), 16'(e));
    chk({tag, ".state"}, 16'(state), 16'(m_state));
    chk({tag, ".mem_error"}, 16'(mem_error), 16'(m_err));
`ifdef HAZARD_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, 16'(m_stall));
`endif
    @(posedge clk);
    if (reset) begin
      if (!e[6] && m_stall < 65535) m_stall++;
      if (blocked) begin
        m_wait  = (m_state == 2) ? m_wait + 1 : 1;
        m_state = 2;
      end else begin
        m_wait = 0;
        if (expire) m_err = 1'b1;
        m_state = ex_branch_taken ? 0 : (lu ? 1 : 0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    cycle("reset");
    reset = 1'b1;
    cycle("idle");

    // Load-use on rs, then clean cycle; ex_rt=0 never stalls.
    ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    cycle("lu_detect");
    idle_inputs();
    cycle("lu_after");
    ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    cycle("lu_r0");
    ex_MemRead = 1'b1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
    cycle("lu_rt");
    id_uses_rt = 1'b0;
    cycle("lu_rt_unused");
    idle_inputs();

    ex_branch_taken = 1'b1;
    cycle("branch");
    idle_inputs();
    cycle("branch_after");

    // Three-cycle memory wait then release.
    mem_access = 1'b1;
    for (int i = 0; i < 3; i++) cycle("memwait");
    mem_ready = 1'b1;
    cycle("mem_release");
    idle_inputs();

    // Branch held across a wait takes effect at release.
    mem_access = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) cycle("prio_wait");
    mem_ready = 1'b1;
    cycle("prio_release");
    idle_inputs();

    // Branch beats load-use when both are forced.
    ex_branch_taken = 1'b1; ex_MemRead = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    cycle("branch_vs_lu");
    idle_inputs();

    // Watchdog: ready never arrives.
    mem_access = 1'b1;
    for (int i = 0; i < int'(T) + 1; i++) cycle("watchdog");
    idle_inputs();
    for (int i = 0; i < 2; i++) cycle("err_sticky");

    // Asynchronous reset in the middle of a wait.
    mem_access = 1'b1;
    cycle("pre_reset_wait");
    cycle("pre_reset_wait2");
    #2 reset = 1'b0;
    #1;
    chk("async_rst.state", 16'(state), 16'd0);
    chk("async_rst.bubble", 16'(MEMWB_Bubble), 16'd1);
    chk("async_rst.err", 16'(mem_error), 16'd0);
    @(negedge clk);
    idle_inputs();
    cycle("in_reset");
    reset = 1'b1;
    cycle("post_reset");

    // Random traffic over a small register set to hit hazards often.
    for (int i = 0; i < 600; i++) begin
      reset           = ($urandom_range(0, 149) != 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_MemRead      = ($urandom_range(0, 2) == 0);
      ex_rt           = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_access      = ($urandom_range(0, 3) == 0);
      mem_ready       = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
